// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read port, full/empty and
// programmable almost-full/almost-empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_Wr_DV,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic [$clog2(DEPTH)-1:0] i_AF_Level,
  output logic                     o_AF_Flag,
  output logic                     o_Full,
  input  logic                     i_Rd_En,
  output logic                     o_Rd_DV,
  output logic [WIDTH-1:0]         o_Rd_Data,
  input  logic [$clog2(DEPTH)-1:0] i_AE_Level,
  output logic                     o_AE_Flag,
  output logic                     o_Empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_rd_ok, w_wr_ok;
  assign w_rd_ok = i_Rd_En && (r_count != '0);
  // a full FIFO still takes a write when a read frees a slot on the same edge
  assign w_wr_ok = i_Wr_DV && ((r_count != CW'(DEPTH)) || w_rd_ok);
  always_ff @(posedge i_Clk)
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_Wr_Data;
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      o_Rd_DV   <= 1'b0;
      o_Rd_Data <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      if (w_rd_ok) o_Rd_Data <= r_mem[r_rd_ptr];
      r_count <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
      o_Rd_DV <= w_rd_ok;
    end
  assign o_Empty   = (r_count == '0);
  assign o_Full    = (r_count == CW'(DEPTH));
  assign o_AE_Flag = (r_count < CW'(i_AE_Level));
  assign o_AF_Flag = (r_count > CW'(DEPTH) - CW'(i_AF_Level));
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random stimulus against a queue-based reference
// model; read data is scoreboarded by an independent monitor.
module tb_sync_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH);
  logic             clk = 1'b0, rst = 1'b1;
  logic             wr_dv = 1'b0, rd_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [LW-1:0]    af_lvl = LW'(3), ae_lvl = LW'(1);
  logic             af, full, rd_dv, ae, empty;
  logic [WIDTH-1:0] rd_data;
  int               n_cmp = 0, n_err = 0;
  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q [$];
  logic             exp_dv = 1'b0;
  logic [WIDTH-1:0] last_data = '0;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data),
    .i_AF_Level(af_lvl), .o_AF_Flag(af), .o_Full(full), .i_Rd_En(rd_en),
    .o_Rd_DV(rd_dv), .o_Rd_Data(rd_data), .i_AE_Level(ae_lvl),
    .o_AE_Flag(ae), .o_Empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string tag);
    int cnt;
    cnt = model_q.size();
    chk({tag, " empty"}, int'(empty), int'(cnt == 0));
    chk({tag, " full"}, int'(full), int'(cnt == DEPTH));
    chk({tag, " ae"}, int'(ae), int'(cnt < int'(ae_lvl)));
    chk({tag, " af"}, int'(af), int'((DEPTH - cnt) < int'(af_lvl)));
  endtask

  // one clock: drive, let the edge happen, advance the model, check flags
  task automatic cycle(input logic wr, input logic [WIDTH-1:0] d, input logic rd);
    bit rd_ok, wr_ok;
    wr_dv = wr; wr_data = d; rd_en = rd;
    @(posedge clk);
    rd_ok = rd && model_q.size() > 0;
    wr_ok = wr && (model_q.size() < DEPTH || rd_ok);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    exp_dv = rd_ok;
    if (wr_ok) model_q.push_back(d);
    #1;
    chk_flags("flags");
  endtask

  task automatic async_reset();
    wr_dv = 1'b0; rd_en = 1'b0;
    rst = 1'b1;
    #1;
    model_q.delete(); exp_q.delete(); exp_dv = 1'b0; last_data = '0;
    chk("async rst empty", int'(empty), 1);
    chk("async rst full", int'(full), 0);
    chk("async rst rd_dv", int'(rd_dv), 0);
    #2 rst = 1'b0;
  endtask

  // monitor: checks every read response against the scoreboard
  always @(negedge clk) if (!rst) begin
    chk("rd_dv", int'(rd_dv), int'(exp_dv));
    if (rd_dv) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_data: unexpected word %0h with empty scoreboard", rd_data);
      end else begin
        chk("rd_data", int'(rd_data), int'(exp_q[0]));
        last_data = exp_q.pop_front();
      end
    end else chk("rd_data hold", int'(rd_data), int'(last_data));
  end

  initial begin
    #12;
    chk("reset empty", int'(empty), 1);
    chk("reset full", int'(full), 0);
    chk("reset ae", int'(ae), 1);
    chk("reset af", int'(af), 0);
    chk("reset rd_dv", int'(rd_dv), 0);
    chk("reset rd_data", int'(rd_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    // single word round trip
    cycle(1, 8'hAB, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    // fill then four separate reads
    for (int i = 0; i < 4; i++) cycle(1, WIDTH'(8'h30 + i), 0);
    for (int i = 0; i < 4; i++) begin cycle(0, 0, 1); cycle(0, 0, 0); end
    // continuous write from reset walks the flag thresholds
    async_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) cycle(1, WIDTH'(8'h40 + i), 0);
    // drain, then rd+wr from empty, fill, rd+wr while full
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    cycle(1, 8'h50, 1);
    cycle(1, 8'h51, 1);
    for (int i = 0; i < 4; i++) cycle(1, WIDTH'(8'h52 + i), 0);
    cycle(1, 8'h60, 1);
    cycle(1, 8'h61, 1);
    // write while full is dropped; read on empty is ignored
    cycle(1, 8'hEE, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1);
    // random traffic with random thresholds, and a mid-stream reset
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) begin
        af_lvl = LW'($urandom_range(DEPTH - 1));
        ae_lvl = LW'($urandom_range(DEPTH - 1));
      end
      if (i == 1000) begin
        cycle(1, 8'h11, 0);
        async_reset();
        @(posedge clk); #1;
      end
      cycle(1'($urandom_range(1)), WIDTH'($urandom), 1'($urandom_range(2) == 0 ? 0 : 1));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 1);
    cycle(0, 0, 0);
    @(negedge clk); #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
